exec_controller: RTL
====================

Name: exec_controller

Overview:
- Run/step controller for the pipelined processor on the board.
- Debounces two raw push-buttons (run/stop, single-step).
- Sequences the CPU clock-enable: free-running at a selectable rate, single instruction cycle, or stopped, and latches a permanent halt when the CPU requests one.
- Sits between the board buttons and the processor core's global enable.

Parameters:
- DEBOUNCE_CYCLES, 131072, consecutive low cycles before a button press is accepted.
- RATE_SHIFT, 8, log2 step between run-rate settings.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- btn_run  in  1  raw run/stop button, active-low (0 = pressed)
- btn_step  in  1  raw single-step button, active-low
- div_sel  in  2  run rate; enable period = 2^(div_sel*RATE_SHIFT) cycles
- halt_req  in  1  level from CPU; 1 = halt instruction reached
- cpu_en  out  1  clock-enable to the processor pipeline
- running  out  1  1 while in RUN
- halted  out  1  1 while in HALTED
- step_count  out  16  number of cpu_en cycles issued, wraps at 65535 -> 0

Behaviour:
- Reset (reset==0 at a clock edge):
  - state <= STOP.
  - Both debounce counters, the rate counter, step_count and the press pulses <= 0.
  - cpu_en = running = halted = 0.
- Debounce (one instance per button):
  - 32-bit counter.
  - Button raw==1: counter <= 0.
  - Button raw==0: counter increments, saturating at DEBOUNCE_CYCLES+1.
  - Registered press pulse is 1 for exactly the one cycle after the counter equals DEBOUNCE_CYCLES.
  - Result: one pulse per continuous hold, first pulse DEBOUNCE_CYCLES+1 edges after the first low sample.
  - A glitch high restarts the count.
- FSM states: STOP, RUN, STEP, HALTED (registered).
  - STOP:
    - run_press -> RUN, rate counter <= 0.
    - Otherwise step_press -> STEP.
    - Run press wins if both pulse in the same cycle.
  - RUN:
    - halt_req==1 -> HALTED.
    - Else run_press -> STOP.
    - step_press ignored.
  - STEP:
    - Lasts exactly one cycle.
    - Next state HALTED if halt_req==1, else STOP.
    - Presses during STEP ignored.
  - HALTED:
    - All presses ignored; exit only via reset.
- Rate counter (24 bits), RUN only:
  - period = 1 << (div_sel*RATE_SHIFT); div_sel=3 gives 2^24.
  - rate_hit = (counter >= period-1).
  - On rate_hit, counter <= 0; otherwise counter increments.
  - Cleared outside RUN.
  - The >= compare handles div_sel lowered mid-run: hit on the next cycle, then the new period.
- cpu_en (combinational from registered state):
  - (state==STEP) OR (state==RUN AND rate_hit AND halt_req==0).
  - With div_sel=0, cpu_en is 1 on every RUN cycle, starting on the first RUN cycle.
- running = (state==RUN); halted = (state==HALTED); both decoded from registered state.
- step_count increments on every clock edge where cpu_en==1.
- halt_req==1 in RUN blocks cpu_en in that same cycle.
- Reset mid-operation (any state, mid-debounce, mid-period) returns everything to reset values on that edge; no pending press survives.

Test Plan (bench uses DEBOUNCE_CYCLES=4, RATE_SHIFT=2):
- Reset: hold reset=0 for 3 cycles with buttons high -> cpu_en=running=halted=0, step_count=0.
- Step debounce: btn_step low for 3 cycles then high -> no cpu_en. Then low for 10 cycles -> exactly one cpu_en pulse, step_count=1, state back in STOP, no repeat while held.
- Run rate: div_sel=1, press run -> running=1, cpu_en high every 4th cycle. After 20 RUN cycles step_count=5. Second run press -> running=0, cpu_en stays 0.
- Rate change: in RUN with div_sel=2 (period 16), counter at 10, set div_sel=0 -> cpu_en on the next cycle, then every cycle.
- Halt: in RUN with div_sel=0, assert halt_req -> cpu_en=0 that cycle, halted=1 next cycle. Further run/step presses leave cpu_en=0 until reset.
- Simultaneous presses and mid-run reset: both buttons pulse in the same STOP cycle -> RUN, step ignored. Pulse reset=0 in RUN -> STOP, step_count=0.

Source files
------------

// File: rtl/exec_controller.sv
// Run/step controller: debounces run/step buttons and sequences the CPU clock-enable.
// Latency: press accepted DEBOUNCE_CYCLES+1 edges after first low sample; cpu_en is combinational from state.
// Backpressure: none; halt_req gates cpu_en in the same cycle and latches HALTED until reset.
module exec_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 131072,
    parameter int unsigned RATE_SHIFT      = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        btn_run,
    input  logic        btn_step,
    input  logic [1:0]  div_sel,
    input  logic        halt_req,
    output logic        cpu_en,
    output logic        running,
    output logic        halted,
    output logic [15:0] step_count
);

    typedef enum logic [1:0] {
        ST_STOP   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    localparam logic [31:0] DB_HIT = 32'(DEBOUNCE_CYCLES);
    localparam logic [31:0] DB_MAX = 32'(DEBOUNCE_CYCLES) + 32'd1;

    state_t      state_q;
    state_t      state_d;
    logic [1:0]  raw;
    logic [31:0] db_cnt [2];
    logic [1:0]  press;
    logic        run_press;
    logic        step_press;
    logic [23:0] rate_cnt;
    logic [31:0] period_m1;
    logic        rate_hit;

    assign raw        = {btn_step, btn_run};
    assign run_press  = press[0];
    assign step_press = press[1];

    // Counter saturates one past the threshold so a held button pulses only once.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
            press <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (raw[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] != DB_MAX) begin
                    db_cnt[i] <= db_cnt[i] + 32'd1;
                end
                press[i] <= (db_cnt[i] == DB_HIT);
            end
        end
    end

    // >= rather than == so lowering div_sel mid-period hits immediately.
    always_comb begin
        period_m1 = (32'd1 << (32'(div_sel) * RATE_SHIFT)) - 32'd1;
        rate_hit  = ({8'd0, rate_cnt} >= period_m1);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STOP: begin
                if (run_press) begin
                    state_d = ST_RUN;
                end else if (step_press) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN: begin
                if (halt_req) begin
                    state_d = ST_HALTED;
                end else if (run_press) begin
                    state_d = ST_STOP;
                end
            end
            ST_STEP:   state_d = halt_req ? ST_HALTED : ST_STOP;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_STOP;
        endcase
    end

    assign cpu_en  = (state_q == ST_STEP) ||
                     ((state_q == ST_RUN) && rate_hit && !halt_req);
    assign running = (state_q == ST_RUN);
    assign halted  = (state_q == ST_HALTED);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= ST_STOP;
            rate_cnt   <= '0;
            step_count <= '0;
        end else begin
            state_q    <= state_d;
            step_count <= step_count + 16'(cpu_en);
            if (state_q == ST_RUN) begin
                rate_cnt <= rate_hit ? 24'd0 : rate_cnt + 24'd1;
            end else begin
                rate_cnt <= '0;
            end
        end
    end

endmodule
